// File: rtl/enc_idx_fifo.sv
// enc_idx_fifo
// Buffering stage ahead of the binary-to-one-hot encoder. Producers push 4-bit
// channel indexes with a valid/ready handshake into a first-word-fall-through
// FIFO. The head entry is presented as (out_valid, out) for the encoder.
// Code 15 has no one-hot equivalent, so it is never stored. Each dropped 15 is
// counted in a saturating 8-bit counter.
//
// Optional feature: macro ENC_IDX_FIFO_BYPASS_EN. When it is defined and the
// FIFO is empty, a legal push made together with pop_en is passed straight to
// the output in the same cycle and is not stored.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   producer offers an index
//   in         producer index (0..15)
//   in_ready   FIFO can accept (= !full)
//   pop_en     downstream consumes the head this cycle
//   out_valid  head entry present
//   out        head index (0 when empty)
//   level      number of stored entries (0..DEPTH)
//   full       level == DEPTH
//   empty      level == 0
//   drop_cnt   saturating count of dropped code-15 pushes
module enc_idx_fifo #(
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    in,
    output logic          in_ready,
    input  logic          pop_en,
    output logic          out_valid,
    output logic [3:0]    out,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic [7:0]    drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic push_try;
    logic legal;
    logic drop;
    logic bypass;
    logic wr_en;
    logic rd_en;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    // No pass-through when full, even if a pop happens in the same cycle.
    assign in_ready = !full;

    assign push_try = in_valid && in_ready;
    assign legal    = (in != 4'hF);
    assign drop     = push_try && !legal;

`ifdef ENC_IDX_FIFO_BYPASS_EN
    assign bypass = empty && push_try && legal && pop_en;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed index is consumed on its way through and never written.
    assign wr_en = push_try && legal && !bypass;
    assign rd_en = !empty && pop_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in;
        end
    end

    always_comb begin
        out_valid = !empty;
        out       = empty ? 4'd0 : mem[rd_ptr];
        if (bypass) begin
            out_valid = 1'b1;
            out       = in;
        end
    end

endmodule

// File: tb/tb_enc_idx_fifo.sv
module tb_enc_idx_fifo;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [3:0]    in;
    logic          in_ready;
    logic          pop_en;
    logic          out_valid;
    logic [3:0]    out;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic [7:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    enc_idx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .pop_en    (pop_en),
        .out_valid (out_valid),
        .out       (out),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in = 4'd0; pop_en = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in = 4'd3; pop_en = 1'b0;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
        checks++; if (out !== 4'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
        checks++; if ({empty, full} !== 2'b10) begin failures++; $display("FAIL reset_empty_full got=%b exp=10", {empty, full}); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_order();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'd3; exp_seq[1] = 4'd7; exp_seq[2] = 4'd14;
        do_reset();
        in_valid = 1'b1; pop_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in = exp_seq[i];
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd3) begin failures++; $display("FAIL order_level got=%0d exp=3", level); end
        pop_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out !== exp_seq[i]) begin
                failures++; $display("FAIL order_pop%0d got=%0d/%0d exp=1/%0d", i, out_valid, out, exp_seq[i]);
            end
            cyc();
        end
        checks++; if ({empty, out_valid, out} !== {1'b1, 1'b0, 4'd0}) begin failures++; $display("FAIL order_empty got=%b exp=100000", {empty, out_valid, out}); end
        pop_en = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        in_valid = 1'b1; pop_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in = 4'(i);
            cyc();
        end
        in = 4'd9;
        checks++; if ({full, in_ready} !== 2'b10) begin failures++; $display("FAIL full_flags got=%b exp=10", {full, in_ready}); end
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_level got=%0d exp=8", level); end
        cyc();
        checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_push9_level got=%0d exp=8", level); end
        in = 4'd15;
        cyc();
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL full_push15_drop got=%0d exp=0", drop_cnt); end
        in_valid = 1'b0; pop_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out !== 4'(i)) begin failures++; $display("FAIL full_drain%0d got=%0d exp=%0d", i, out, i); end
            cyc();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained_empty got=%0d exp=1", empty); end
        cyc();
        checks++; if ({level, out_valid} !== {4'd0, 1'b0}) begin failures++; $display("FAIL pop_while_empty got=%0d/%0d exp=0/0", level, out_valid); end
        pop_en = 1'b0;
    endtask

    task automatic test_drop();
        logic [3:0] seq [4];
        seq[0] = 4'd15; seq[1] = 4'd5; seq[2] = 4'd15; seq[3] = 4'd15;
        do_reset();
        in_valid = 1'b1; pop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in = seq[i];
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd1) begin failures++; $display("FAIL drop_level got=%0d exp=1", level); end
        checks++; if (out !== 4'd5) begin failures++; $display("FAIL drop_head got=%0d exp=5", out); end
        checks++; if (drop_cnt !== 8'd3) begin failures++; $display("FAIL drop_cnt3 got=%0d exp=3", drop_cnt); end
        in_valid = 1'b1; in = 4'd15; pop_en = 1'b1;
        cyc();
        pop_en = 1'b0;
        checks++; if ({level, drop_cnt} !== {4'd0, 8'd4}) begin failures++; $display("FAIL drop_with_pop got=%0d/%0d exp=0/4", level, drop_cnt); end
        repeat (250) cyc();
        checks++; if (drop_cnt !== 8'd254) begin failures++; $display("FAIL drop_cnt254 got=%0d exp=254", drop_cnt); end
        repeat (50) cyc();
        checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_cnt_sat got=%0d exp=255", drop_cnt); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL drop_no_store got=%0d exp=0", level); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] q [$];
        logic [3:0] v;
        do_reset();
        in_valid = 1'b1; pop_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in = 4'(i);
            cyc();
            q.push_back(4'(i));
        end
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL b2b_level_pre got=%0d exp=4", level); end
        in = 4'd11; pop_en = 1'b1;
        cyc();
        void'(q.pop_front());
        q.push_back(4'd11);
        checks++; if ({level, out} !== {4'd4, 4'd2}) begin failures++; $display("FAIL b2b_push_pop got=%0d/%0d exp=4/2", level, out); end
        for (int i = 0; i < 20; i++) begin
            v = 4'(i % 15);
            checks++;
            if (out !== q[0]) begin failures++; $display("FAIL b2b_wrap%0d got=%0d exp=%0d", i, out, q[0]); end
            in = v;
            cyc();
            void'(q.pop_front());
            q.push_back(v);
        end
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL b2b_level_post got=%0d exp=4", level); end
        in_valid = 1'b0; pop_en = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        in_valid = 1'b1; in = 4'd6; pop_en = 1'b1;
        #1;
`ifdef ENC_IDX_FIFO_BYPASS_EN
        checks++; if ({out_valid, out} !== {1'b1, 4'd6}) begin failures++; $display("FAIL bypass_same_cycle got=%0d/%0d exp=1/6", out_valid, out); end
        cyc();
        in_valid = 1'b0; pop_en = 1'b0;
        #1;
        checks++; if ({level, out_valid} !== {4'd0, 1'b0}) begin failures++; $display("FAIL bypass_not_stored got=%0d/%0d exp=0/0", level, out_valid); end
`else
        checks++; if ({out_valid, out} !== {1'b0, 4'd0}) begin failures++; $display("FAIL nobypass_same_cycle got=%0d/%0d exp=0/0", out_valid, out); end
        cyc();
        in_valid = 1'b0; pop_en = 1'b0;
        #1;
        checks++; if ({out_valid, out, level} !== {1'b1, 4'd6, 4'd1}) begin failures++; $display("FAIL nobypass_next_cycle got=%0d/%0d/%0d exp=1/6/1", out_valid, out, level); end
        pop_en = 1'b1;
        cyc();
        pop_en = 1'b0;
`endif
        in_valid = 1'b1; in = 4'd15; pop_en = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL code15_no_bypass got=%0d exp=0", out_valid); end
        cyc();
        in_valid = 1'b0; pop_en = 1'b0;
        checks++; if ({level, drop_cnt} !== {4'd0, 8'd1}) begin failures++; $display("FAIL code15_counted got=%0d/%0d exp=0/1", level, drop_cnt); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = 4'd0; pop_en = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_drop();
        test_back_to_back();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
